interrupt_controller: RTL and testbench
=======================================

Name: interrupt_controller

Overview:
- MMIO interrupt controller for the GB80 CPU. Consumes the one-cycle request pulses raised by the peripherals (timers, LCD, serial, joypad).
- Holds the IF (0xFF0F) and IE (0xFFFF) registers on the shared addr_ext/data_ext bus.
- Presents a prioritised, stable vector to the CPU core through a pending/ack handshake.
- Sits between the peripheral interrupt outputs and the CPU control unit.

Parameters:
- VEC_BASE, 16'h0040, address of the bit-0 (highest-priority) handler.
- VEC_STRIDE, 8, byte spacing between consecutive handler vectors.

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- addr_ext  inout  16  shared address bus; this block only samples it.
- data_ext  inout  8  shared data bus; driven only during a matching read, high-Z otherwise.
- mem_re  input  1  bus read strobe.
- mem_we  input  1  bus write strobe.
- int_req  input  5  request pulses: [0] vblank, [1] lcd stat, [2] timer, [3] serial, [4] joypad.
- ime  input  1  CPU master interrupt enable.
- int_ack  input  1  CPU accepts the presented vector; one-cycle pulse.
- int_pending  output  1  a vector is being presented to the CPU.
- int_vector  output  16  handler address; valid while int_pending=1.
- int_wake  output  1  combinational |(IF & IE[4:0]), independent of ime; releases HALT.

Behaviour:
- Reset values: IF=5'b0, IE=8'h00, state IDLE, int_pending=0, int_vector=16'h0000, index register=0.

Bus access:
- Read of MMIO_IF drives {3'b111, IF}.
- Read of MMIO_IE drives all 8 bits of IE.
- All other addresses, or mem_re=0: high-Z.
- Write sampled at the clock edge when mem_we is high and the address matches. IF takes data_ext[4:0]; IE takes data_ext[7:0].

IF update precedence within one cycle, per bit, highest first:
- int_req set. A request is never lost, even against a same-cycle write of 0 or an ack clear.
- Bus write.
- Ack clear of the latched bit.
- Hold.

Candidate selection:
- masked = IF & IE[4:0].
- Selected index = lowest set bit of masked (bit 0 highest priority).
- Vector = VEC_BASE + VEC_STRIDE*index, computed as 16-bit, no overflow for indices 0..4.

State machine, states IDLE and PEND:
- IDLE -> PEND when ime=1 and masked != 0. Latch index and int_vector. int_pending=1 from the next cycle (1-cycle latency from IF set to pending).
- In PEND, int_vector and index are frozen. A later higher-priority request does not preempt.
- PEND with int_ack=1: clear IF[index] (subject to precedence), int_pending=0, go to IDLE. The earliest next PEND is one cycle later.
- PEND with ime=0 or IF[index]&IE[index]=0 (software cleared it) and no ack: cancel. Go to IDLE, int_pending=0, IF unchanged.
- Cancel and ack in the same cycle: ack wins, bit cleared.
- int_ack in IDLE: ignored, no IF change.
- int_vector holds its last value in IDLE. Only int_pending qualifies it.

Other rules:
- int_wake tracks masked combinationally, regardless of state or ime.
- Reset asserted mid-PEND: immediate return to reset values, pending request dropped.

Test Plan:
- Reset; read 0xFF0F -> 8'hE0; read 0xFFFF -> 8'h00; int_pending=0; data_ext high-Z when no matching read.
- Write IE=8'h04, ime=1, pulse int_req[2] -> IF=5'b00100; int_pending=1 one cycle later with int_vector=16'h0050. Pulse int_ack -> IF=0, int_pending=0 next cycle.
- IE=8'h1F, same-cycle int_req=5'b10110 -> vector 16'h0048 (bit 1). After ack, the next PEND gives 16'h0050, then 16'h0060. IF ends 0.
- While PEND on 16'h0050, pulse int_req[0] -> int_vector stays 16'h0050 until ack. The following cycle cycle sequence then presents 16'h0040.
- PEND on timer, drop ime -> int_pending=0, IF[2] still 1, int_wake=1. Raise ime -> PEND re-enters with 16'h0050.
- int_req[2] pulse coincident with int_ack of timer -> IF[2] stays 1, PEND re-enters. Bus write IF=0 coincident with int_req[3] -> IF=5'b01000.

Source files
------------

// File: rtl/interrupt_controller_if.sv
// CPU-side handshake of the interrupt controller: enable/ack in, vector/pending/wake out.
interface interrupt_controller_if;
    logic        ime;
    logic        int_ack;
    logic        int_pending;
    logic [15:0] int_vector;
    logic        int_wake;

    modport master (
        output ime,
        output int_ack,
        input  int_pending,
        input  int_vector,
        input  int_wake
    );

    modport slave (
        input  ime,
        input  int_ack,
        output int_pending,
        output int_vector,
        output int_wake
    );
endinterface

// File: rtl/interrupt_controller.sv
// GB80 interrupt controller: IF/IE MMIO registers, fixed-priority selection and a
// two-state pending/ack handshake that presents a frozen vector to the CPU.
module interrupt_controller #(
    parameter logic [15:0] VEC_BASE   = 16'h0040,
    parameter int unsigned VEC_STRIDE = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    inout  wire  [15:0]                  addr_ext,
    inout  wire  [7:0]                   data_ext,
    input  logic                         mem_re,
    input  logic                         mem_we,
    input  logic [4:0]                   int_req,
    interrupt_controller_if.slave        cpu
);

    localparam logic [15:0] MMIO_IF = 16'hFF0F;
    localparam logic [15:0] MMIO_IE = 16'hFFFF;

    typedef enum logic [0:0] {StIdle, StPend} state_e;

    state_e      state_q;
    logic [4:0]  if_q;
    logic [4:0]  if_d;
    logic [7:0]  ie_q;
    logic [2:0]  idx_q;
    logic        pending_q;
    logic [15:0] vector_q;

    logic        hit_if;
    logic        hit_ie;
    logic        wr_if;
    logic        wr_ie;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic [4:0]  masked;
    logic [2:0]  sel_idx;
    logic [15:0] sel_vec;
    logic [4:0]  ack_clr;
    logic        ack_now;
    logic        cur_live;

    assign hit_if = (addr_ext == MMIO_IF);
    assign hit_ie = (addr_ext == MMIO_IE);
    assign wr_if  = mem_we && hit_if;
    assign wr_ie  = mem_we && hit_ie;
    assign rd_en  = mem_re && (hit_if || hit_ie);

    always_comb begin
        rd_data = 8'h00;
        if (hit_if) begin
            rd_data = {3'b111, if_q};
        end else if (hit_ie) begin
            rd_data = ie_q;
        end
    end

    assign data_ext = rd_en ? rd_data : 8'hzz;

    assign masked       = if_q & ie_q[4:0];
    assign cpu.int_wake = |masked;

    // Lowest set bit wins: scan from the top so bit 0 overwrites last.
    always_comb begin
        sel_idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (masked[i]) begin
                sel_idx = 3'(i);
            end
        end
    end

    assign sel_vec = VEC_BASE + 16'(VEC_STRIDE * sel_idx);

    assign ack_now  = (state_q == StPend) && cpu.int_ack;
    assign ack_clr  = ack_now ? (5'b00001 << idx_q) : 5'b00000;
    assign cur_live = if_q[idx_q] & ie_q[idx_q];

    // Per bit: request beats bus write beats ack clear, so no request is ever lost.
    always_comb begin
        if_d = if_q;
        for (int b = 0; b < 5; b++) begin
            if (int_req[b]) begin
                if_d[b] = 1'b1;
            end else if (wr_if) begin
                if_d[b] = data_ext[b];
            end else if (ack_clr[b]) begin
                if_d[b] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            if_q      <= 5'b0;
            ie_q      <= 8'h00;
            idx_q     <= 3'd0;
            pending_q <= 1'b0;
            vector_q  <= 16'h0000;
        end else begin
            if_q <= if_d;
            if (wr_ie) begin
                ie_q <= data_ext;
            end
            unique case (state_q)
                StIdle: begin
                    if (cpu.ime && (masked != 5'b0)) begin
                        state_q   <= StPend;
                        idx_q     <= sel_idx;
                        vector_q  <= sel_vec;
                        pending_q <= 1'b1;
                    end
                end
                StPend: begin
                    // Ack takes priority over a simultaneous cancel.
                    if (cpu.int_ack || !cpu.ime || !cur_live) begin
                        state_q   <= StIdle;
                        pending_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    pending_q <= 1'b0;
                end
            endcase
        end
    end

    assign cpu.int_pending = pending_q;
    assign cpu.int_vector  = vector_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed-vector bench for interrupt_controller with hand-computed expectations.
module tb_interrupt_controller;

    logic        clock;
    logic        reset;
    logic [15:0] tb_addr;
    logic [7:0]  tb_data;
    logic        tb_drv;
    logic        mem_re;
    logic        mem_we;
    logic [4:0]  int_req;
    wire  [15:0] addr_ext;
    wire  [7:0]  data_ext;

    int n_cmp;
    int n_bad;

    interrupt_controller_if cpu_if ();

    assign addr_ext = tb_addr;
    assign data_ext = tb_drv ? tb_data : 8'hzz;

    interrupt_controller dut (
        .clock    (clock),
        .reset    (reset),
        .addr_ext (addr_ext),
        .data_ext (data_ext),
        .mem_re   (mem_re),
        .mem_we   (mem_we),
        .int_req  (int_req),
        .cpu      (cpu_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        tb_addr = a;
        tb_data = d;
        tb_drv  = 1'b1;
        mem_we  = 1'b1;
        tick();
        mem_we  = 1'b0;
        tb_drv  = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        tb_addr = a;
        mem_re  = 1'b1;
        #1;
        d = data_ext;
        mem_re  = 1'b0;
        #1;
    endtask

    task automatic pulse_req(input logic [4:0] r);
        int_req = r;
        tick();
        int_req = 5'b0;
    endtask

    task automatic ack();
        cpu_if.int_ack = 1'b1;
        tick();
        cpu_if.int_ack = 1'b0;
    endtask

    logic [7:0] rd;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        tb_addr = 16'h0000;
        tb_data = 8'h00;
        tb_drv  = 1'b0;
        mem_re  = 1'b0;
        mem_we  = 1'b0;
        int_req = 5'b0;
        cpu_if.ime     = 1'b0;
        cpu_if.int_ack = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_pending", 32'(cpu_if.int_pending), 32'd0);
        check("rst_vector", 32'(cpu_if.int_vector), 32'h0000);
        check("rst_wake", 32'(cpu_if.int_wake), 32'd0);
        bus_read(16'hFF0F, rd);
        check("rst_if", 32'(rd), 32'hE0);
        bus_read(16'hFFFF, rd);
        check("rst_ie", 32'(rd), 32'h00);

        // Single timer request, one-cycle latency, ack clears it
        bus_write(16'hFFFF, 8'h04);
        cpu_if.ime = 1'b1;
        pulse_req(5'b00100);
        check("t1_latency", 32'(cpu_if.int_pending), 32'd0);
        bus_read(16'hFF0F, rd);
        check("t1_if_set", 32'(rd), 32'hE4);
        check("t1_wake", 32'(cpu_if.int_wake), 32'd1);
        tick();
        check("t1_pending", 32'(cpu_if.int_pending), 32'd1);
        check("t1_vector", 32'(cpu_if.int_vector), 32'h0050);
        ack();
        check("t1_ack_pend", 32'(cpu_if.int_pending), 32'd0);
        bus_read(16'hFF0F, rd);
        check("t1_ack_if", 32'(rd), 32'hE0);

        // Multiple simultaneous requests served in priority order
        bus_write(16'hFFFF, 8'h1F);
        bus_read(16'hFFFF, rd);
        check("t2_ie", 32'(rd), 32'h1F);
        pulse_req(5'b10110);
        tick();
        check("t2_vec_a", 32'(cpu_if.int_vector), 32'h0048);
        ack();
        check("t2_gap", 32'(cpu_if.int_pending), 32'd0);
        tick();
        check("t2_vec_b", 32'(cpu_if.int_vector), 32'h0050);
        ack();
        tick();
        check("t2_vec_c", 32'(cpu_if.int_vector), 32'h0060);
        check("t2_pend_c", 32'(cpu_if.int_pending), 32'd1);
        ack();
        bus_read(16'hFF0F, rd);
        check("t2_if_end", 32'(rd), 32'hE0);

        // No preemption while pending
        pulse_req(5'b00100);
        tick();
        check("t3_vec", 32'(cpu_if.int_vector), 32'h0050);
        pulse_req(5'b00001);
        check("t3_frozen", 32'(cpu_if.int_vector), 32'h0050);
        tick();
        check("t3_frozen2", 32'(cpu_if.int_vector), 32'h0050);
        check("t3_still_pend", 32'(cpu_if.int_pending), 32'd1);
        ack();
        tick();
        check("t3_vblank", 32'(cpu_if.int_vector), 32'h0040);
        ack();
        bus_read(16'hFF0F, rd);
        check("t3_if_end", 32'(rd), 32'hE0);

        // Cancel on ime drop, then re-enter
        pulse_req(5'b00100);
        tick();
        check("t4_pend", 32'(cpu_if.int_pending), 32'd1);
        cpu_if.ime = 1'b0;
        tick();
        check("t4_cancel", 32'(cpu_if.int_pending), 32'd0);
        bus_read(16'hFF0F, rd);
        check("t4_if_kept", 32'(rd), 32'hE4);
        check("t4_wake", 32'(cpu_if.int_wake), 32'd1);
        cpu_if.ime = 1'b1;
        tick();
        check("t4_reenter", 32'(cpu_if.int_pending), 32'd1);
        check("t4_revec", 32'(cpu_if.int_vector), 32'h0050);

        // Request coincident with its own ack survives
        int_req = 5'b00100;
        ack();
        int_req = 5'b00000;
        check("t5_ack_pend", 32'(cpu_if.int_pending), 32'd0);
        bus_read(16'hFF0F, rd);
        check("t5_if_kept", 32'(rd), 32'hE4);
        tick();
        check("t5_reenter", 32'(cpu_if.int_pending), 32'd1);

        // Software clear of IF cancels without ack
        bus_write(16'hFF0F, 8'h00);
        tick();
        check("t6_sw_cancel", 32'(cpu_if.int_pending), 32'd0);
        check("t6_wake", 32'(cpu_if.int_wake), 32'd0);

        // Request beats same-cycle bus write of 0
        cpu_if.ime = 1'b0;
        int_req = 5'b01000;
        bus_write(16'hFF0F, 8'h00);
        int_req = 5'b00000;
        bus_read(16'hFF0F, rd);
        check("t7_req_wins", 32'(rd), 32'hE8);

        // Ack while idle is ignored
        ack();
        bus_read(16'hFF0F, rd);
        check("t7_idle_ack", 32'(rd), 32'hE8);
        check("t7_vec_hold", 32'(cpu_if.int_vector), 32'h0050);

        // Async reset in the middle of a pending request
        cpu_if.ime = 1'b1;
        tick();
        check("t8_pend", 32'(cpu_if.int_pending), 32'd1);
        check("t8_vec", 32'(cpu_if.int_vector), 32'h0058);
        #2;
        reset = 1'b1;
        #1;
        check("t8_rst_pend", 32'(cpu_if.int_pending), 32'd0);
        check("t8_rst_vec", 32'(cpu_if.int_vector), 32'h0000);
        bus_read(16'hFFFF, rd);
        check("t8_rst_ie", 32'(rd), 32'h00);
        bus_read(16'hFF0F, rd);
        check("t8_rst_if", 32'(rd), 32'hE0);
        reset = 1'b0;
        tick();
        tick();
        check("t8_after", 32'(cpu_if.int_pending), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
